// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: IF stage of a 5-stage MIPS pipeline.
//
// This block holds the PC and chooses the next PC from these sources:
//   branch redirect (EX/MEM), stall, J/JAL, JR/JALR, or PC+4.
// It also latches the fetched word, PC+4 and a valid bit into the IF/ID register.
// The instruction memory is external and reads combinationally (o_pc -> i_instr).
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_enable                global pipeline enable; 0 freezes all state (reset still wins)
//   i_pc_write, i_IFID_write, i_flush_latch   hazard unit controls
//   i_EXMEM_flush, i_branch_target            taken-branch redirect from MEM
//   i_jump, i_jump_target, i_JALR, i_jalr_target   ID-stage jumps
//   i_HALT                  HALT decoded in ID; stops fetch until reset or an older redirect
//   i_instr                 instruction memory read data for o_pc
//   o_pc                    current PC / instruction address
//   o_IFID_instr, o_IFID_pc4, o_IFID_valid    IF/ID register contents
//   o_halted                fetch stopped by HALT
//   o_fetch_count, o_stall_count               perf counters
//
// Optional feature: define IF_PERF_CNT_EN to build the saturating perf counters.
// When it is undefined, both counter outputs are tied to zero.
//
// The PC also holds on the cycle HALT is seen. This stops fetch at the PC that was
// current when HALT reached ID.

module fetch_ifid_stage #(
    parameter int unsigned           BITS_SIZE = 32,
    parameter logic [BITS_SIZE-1:0]  PC_RESET  = '0,
    parameter int unsigned           BITS_CNT  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_pc_write,
    input  logic                 i_IFID_write,
    input  logic                 i_flush_latch,
    input  logic                 i_EXMEM_flush,
    input  logic [BITS_SIZE-1:0] i_branch_target,
    input  logic                 i_jump,
    input  logic [BITS_SIZE-1:0] i_jump_target,
    input  logic                 i_JALR,
    input  logic [BITS_SIZE-1:0] i_jalr_target,
    input  logic                 i_HALT,
    input  logic [BITS_SIZE-1:0] i_instr,
    output logic [BITS_SIZE-1:0] o_pc,
    output logic [BITS_SIZE-1:0] o_IFID_instr,
    output logic [BITS_SIZE-1:0] o_IFID_pc4,
    output logic                 o_IFID_valid,
    output logic                 o_halted,
    output logic [BITS_CNT-1:0]  o_fetch_count,
    output logic [BITS_CNT-1:0]  o_stall_count
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e                state_q, state_d;
    logic [BITS_SIZE-1:0]  pc_q, pc_d;
    logic [BITS_SIZE-1:0]  ifid_instr_q, ifid_instr_d;
    logic [BITS_SIZE-1:0]  ifid_pc4_q, ifid_pc4_d;
    logic                  ifid_valid_q, ifid_valid_d;
    logic [BITS_SIZE-1:0]  pc_plus4;
    logic                  load_valid;

    assign pc_plus4 = pc_q + BITS_SIZE'(4);

    // FSM next state and next PC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (i_enable) begin
            unique case (state_q)
                StRun: begin
                    if (i_EXMEM_flush) begin
                        pc_d = i_branch_target;  // redirect beats stall and HALT
                    end else if (i_HALT) begin
                        state_d = StHalted;
                    end else if (!i_pc_write) begin
                        pc_d = pc_q;
                    end else if (i_jump) begin
                        pc_d = i_jump_target;
                    end else if (i_JALR) begin
                        pc_d = i_jalr_target;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
                StHalted: begin
                    // An older taken branch squashes the younger HALT.
                    if (i_EXMEM_flush) begin
                        pc_d    = i_branch_target;
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // IF/ID latch next value
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        load_valid   = 1'b0;
        if (i_enable) begin
            if (i_flush_latch) begin
                ifid_instr_d = '0;
                ifid_pc4_d   = '0;
                ifid_valid_d = 1'b0;
            end else if (!i_IFID_write) begin
                ifid_valid_d = ifid_valid_q;
            end else if (state_q == StHalted) begin
                ifid_instr_d = '0;
                ifid_pc4_d   = '0;
                ifid_valid_d = 1'b0;
            end else begin
                ifid_instr_d = i_instr;
                ifid_pc4_d   = pc_plus4;
                ifid_valid_d = 1'b1;
                load_valid   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= StRun;
            pc_q         <= PC_RESET;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign o_pc         = pc_q;
    assign o_IFID_instr = ifid_instr_q;
    assign o_IFID_pc4   = ifid_pc4_q;
    assign o_IFID_valid = ifid_valid_q;
    assign o_halted     = (state_q == StHalted);

`ifdef IF_PERF_CNT_EN
    logic [BITS_CNT-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [BITS_CNT-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load_valid && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + BITS_CNT'(1);
        end
        if (i_enable && !i_IFID_write && !i_flush_latch && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + BITS_CNT'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_fetch_count = fetch_cnt_q;
    assign o_stall_count = stall_cnt_q;
`else
    logic unused_load_valid;
    assign unused_load_valid = load_valid;
    assign o_fetch_count     = '0;
    assign o_stall_count     = '0;
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
module tb_fetch_ifid_stage;

    logic        clk = 1'b0;
    logic        rst, en, pcw, ifw, fl, ex, jmp, jalr, halt;
    logic [31:0] bt, jt, jrt, instr;
    logic [31:0] pc, ifid_instr, ifid_pc4, fcnt, scnt;
    logic        ifid_valid, halted;
    logic        const_mode;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;
    logic        m_valid, m_halted;

    always #5 clk = ~clk;

    fetch_ifid_stage dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_pc_write(pcw), .i_IFID_write(ifw),
        .i_flush_latch(fl), .i_EXMEM_flush(ex), .i_branch_target(bt), .i_jump(jmp),
        .i_jump_target(jt), .i_JALR(jalr), .i_jalr_target(jrt), .i_HALT(halt),
        .i_instr(instr), .o_pc(pc), .o_IFID_instr(ifid_instr), .o_IFID_pc4(ifid_pc4),
        .o_IFID_valid(ifid_valid), .o_halted(halted), .o_fetch_count(fcnt),
        .o_stall_count(scnt)
    );

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic cm);
        return cm ? 32'h2001_0005 : ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF);
    endfunction

    always_comb instr = mem_word(pc, const_mode);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; en = 1; pcw = 1; ifw = 1; fl = 0; ex = 0; jmp = 0; jalr = 0; halt = 0;
        bt = 0; jt = 0; jrt = 0;
    endtask

    // One clock: predict from the rules, clock the DUT, compare everything.
    task automatic cycle();
        logic [31:0] n_pc, n_instr, n_pc4, n_fc, n_sc;
        logic        n_valid, n_halted, loaded;
        n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
        n_halted = m_halted; n_fc = m_fc; n_sc = m_sc; loaded = 0;
        if (rst) begin
            n_pc = 0; n_instr = 0; n_pc4 = 0; n_valid = 0; n_halted = 0; n_fc = 0; n_sc = 0;
        end else if (en) begin
            if (ex) n_pc = bt;
            else if (m_halted || halt || !pcw) n_pc = m_pc;
            else if (jmp) n_pc = jt;
            else if (jalr) n_pc = jrt;
            else n_pc = m_pc + 4;
            n_halted = ex ? 1'b0 : (m_halted || halt);
            if (fl) begin
                n_instr = 0; n_pc4 = 0; n_valid = 0;
            end else if (ifw) begin
                if (m_halted) begin
                    n_instr = 0; n_pc4 = 0; n_valid = 0;
                end else begin
                    n_instr = mem_word(m_pc, const_mode); n_pc4 = m_pc + 4; n_valid = 1;
                    loaded = 1;
                end
            end
`ifdef IF_PERF_CNT_EN
            if (loaded && m_fc != 32'hFFFF_FFFF) n_fc = m_fc + 1;
            if (!ifw && !fl && m_sc != 32'hFFFF_FFFF) n_sc = m_sc + 1;
`endif
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
        m_halted = n_halted; m_fc = n_fc; m_sc = n_sc;
        chk("pc", pc, m_pc);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc4", ifid_pc4, m_pc4);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        chk("fetch_count", fcnt, m_fc);
        chk("stall_count", scnt, m_sc);
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0; m_fc = 0; m_sc = 0;
        const_mode = 1;
        idle();

        // 1: reset then three plain fetches
        rst = 1; cycle(); rst = 0;
        chk("reset_pc", pc, 32'h0);
        chk("reset_valid", {31'b0, ifid_valid}, 32'h0);
        repeat (3) cycle();
        chk("t1_pc", pc, 32'd12);
        chk("t1_pc4", ifid_pc4, 32'd12);
        chk("t1_instr", ifid_instr, 32'h2001_0005);

        // 2: stall for two cycles
        pcw = 0; ifw = 0; repeat (2) cycle();
        chk("t2_pc", pc, 32'd12);

        // 3: redirect beats stall, flush squashes IF/ID
        ex = 1; bt = 32'h40; fl = 1; cycle(); idle();
        chk("t3_pc", pc, 32'h40);
        chk("t3_valid", {31'b0, ifid_valid}, 32'h0);

        // 4: jump has priority over JALR
        jmp = 1; jt = 32'h100; jalr = 1; jrt = 32'h200; cycle(); idle();
        chk("t4_pc", pc, 32'h100);

        // 5: HALT at 0x20, then recovery by an older branch
        jmp = 1; jt = 32'h20; cycle(); idle();
        halt = 1; cycle(); idle();
        chk("t5_pc_frozen", pc, 32'h20);
        chk("t5_halted", {31'b0, halted}, 32'h1);
        repeat (2) cycle();
        chk("t5_nop_valid", {31'b0, ifid_valid}, 32'h0);
        chk("t5_pc_still", pc, 32'h20);
        ex = 1; bt = 32'h80; cycle(); idle();
        chk("t5_pc_redirect", pc, 32'h80);
        chk("t5_unhalted", {31'b0, halted}, 32'h0);

        // 6: reset mid-stall with enable low
        pcw = 0; ifw = 0; repeat (2) cycle();
        en = 0; rst = 1; cycle(); idle();
        chk("t6_pc", pc, 32'h0);
        chk("t6_fcnt", fcnt, 32'h0);
        chk("t6_scnt", scnt, 32'h0);

        // PC wrap at the top of the address space
        const_mode = 0;
        jmp = 1; jt = 32'hFFFF_FFF8; cycle(); idle();
        repeat (2) cycle();
        chk("wrap_pc", pc, 32'h0);

        // Enable low freezes everything
        jmp = 1; jt = 32'h500; ex = 1; fl = 1; en = 0; repeat (2) cycle(); idle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 149) == 0);
            en   = ($urandom_range(0, 9) != 0);
            pcw  = ($urandom_range(0, 7) != 0);
            ifw  = ($urandom_range(0, 7) != 0);
            fl   = ($urandom_range(0, 9) == 0);
            ex   = ($urandom_range(0, 11) == 0);
            jmp  = ($urandom_range(0, 5) == 0);
            jalr = ($urandom_range(0, 5) == 0);
            halt = ($urandom_range(0, 24) == 0);
            bt   = $urandom & 32'hFFFF_FFFC;
            jt   = $urandom & 32'hFFFF_FFFC;
            jrt  = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
